// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port RAM between instruction fetch and
// data load/store. Serialises accesses, round-robins on conflicts and hides
// the fixed RAM read latency behind a req/valid handshake.
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned LATENCY = 1   // 1..15; 0 is illegal
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       last_grant;
  logic       grant;
  logic       op_we;
  logic       any_req;
  logic       pick_d;

  // Round-robin choice: on a tie the requester not granted last time wins
  always_comb begin
    any_req = if_req | d_req;
    pick_d  = d_req;
    if (if_req && d_req) begin
      pick_d = (last_grant == GRANT_IF);
    end
  end

  // Access sequencer: grant, issue one mem_en, count out latency, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GRANT_D;
      grant      <= GRANT_IF;
      op_we      <= 1'b0;
      if_rdata   <= '0;
      if_valid   <= 1'b0;
      d_rdata    <= '0;
      d_valid    <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant      <= pick_d;
            last_grant <= pick_d;
            op_we      <= pick_d & d_we;
            mem_we     <= pick_d & d_we;
            mem_addr   <= pick_d ? d_addr : if_addr;
            if (pick_d) begin
              mem_wdata <= d_wdata;
            end
            mem_en     <= 1'b1;
            cnt        <= CNT_LOAD;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          cnt    <= cnt - 4'd1;
          state  <= WAIT;
        end
        WAIT: begin
          if (cnt == 4'd0) begin
            if (grant == GRANT_IF) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end else begin
              if (!op_we) begin
                d_rdata <= mem_rdata;
              end
              d_valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter: three instances (LATENCY 1, 3, 4)
// share the requester inputs; each has its own latency-accurate RAM model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;

  logic [31:0] a_if_rdata, a_d_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_if_valid, a_d_valid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic        b_if_valid, b_d_valid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] c_if_rdata, c_d_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata;
  logic        c_if_valid, c_d_valid, c_mem_en, c_mem_we, c_busy;

  int n_cmp = 0;
  int n_err = 0;
  int b_en_total = 0;

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(a_if_rdata), .if_valid(a_if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(a_d_rdata), .d_valid(a_d_valid),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(b_if_rdata), .if_valid(b_if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(b_d_rdata), .d_valid(b_d_valid),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  mem_port_arbiter #(.AW(32), .DW(32), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(c_if_rdata), .if_valid(c_if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(c_d_rdata), .d_valid(c_d_valid),
    .mem_en(c_mem_en), .mem_we(c_mem_we), .mem_addr(c_mem_addr),
    .mem_wdata(c_mem_wdata), .mem_rdata(c_mem_rdata), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM content is a fixed function of the address
  function automatic logic [31:0] f(input logic [31:0] addr);
    return addr ^ 32'h2041_0005;
  endfunction

  // RAM models: read data appears LATENCY cycles after the mem_en cycle;
  // all-ones otherwise so a mistimed capture is visible
  logic [31:0] p1;
  logic [31:0] p3_0, p3_1, p3_2;
  logic [31:0] p4_0, p4_1, p4_2, p4_3;
  always @(posedge clk) begin
    p1   <= a_mem_en ? f(a_mem_addr) : '1;
    p3_0 <= b_mem_en ? f(b_mem_addr) : '1;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
    p4_0 <= c_mem_en ? f(c_mem_addr) : '1;
    p4_1 <= p4_0;
    p4_2 <= p4_1;
    p4_3 <= p4_2;
    if (b_mem_en) b_en_total <= b_en_total + 1;
  end
  assign a_mem_rdata = p1;
  assign b_mem_rdata = p3_2;
  assign c_mem_rdata = p4_3;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int en_base;
    // Reset with both requests high, LATENCY=1
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_wdata = '0;
    step();
    check("rst_dvalid", a_d_valid, 0);
    check("rst_men", a_mem_en, 0);
    check("rst_busy", a_busy, 0);
    step();
    check("rst_dvalid2", a_d_valid, 0);
    check("rst_ifrdata", a_if_rdata, 0);
    check("rst_maddr", a_mem_addr, 0);
    check("rst_ivalid", a_if_valid, 0);
    rst = 1'b0;                                   // cycle 0
    step();                                       // cycle 1
    check("tie_men", a_mem_en, 1);
    check("tie_maddr", a_mem_addr, 32'h0000_0100);
    check("tie_mwe", a_mem_we, 0);
    step();                                       // cycle 2
    check("tie_men_off", a_mem_en, 0);
    check("tie_busy", a_busy, 1);
    step();                                       // cycle 3
    check("tie_ivalid", a_if_valid, 1);
    check("tie_irdata", a_if_rdata, f(32'h0000_0100));
    check("tie_dvalid0", a_d_valid, 0);
    if_req = 1'b0;
    step();                                       // cycle 4
    check("tie_ivalid_off", a_if_valid, 0);
    check("tie_idle", a_busy, 0);
    step();                                       // cycle 5
    check("d_men", a_mem_en, 1);
    check("d_maddr", a_mem_addr, 32'h0000_0200);
    step(); step();                               // cycle 7
    check("d_dvalid", a_d_valid, 1);
    check("d_drdata", a_d_rdata, f(32'h0000_0200));
    d_req = 1'b0;
    step();
    check("d_dvalid_off", a_d_valid, 0);

    // Fetch only, LATENCY=1
    do_reset();
    if_req = 1'b1; if_addr = 32'h0040_0000;       // cycle 0
    step();
    check("f_men", a_mem_en, 1);
    check("f_mwe", a_mem_we, 0);
    check("f_maddr", a_mem_addr, 32'h0040_0000);
    step();
    check("f_ivalid_early", a_if_valid, 0);
    step();                                       // cycle 3
    check("f_ivalid", a_if_valid, 1);
    check("f_irdata", a_if_rdata, 32'h2001_0005);
    if_req = 1'b0;
    step();
    check("f_ivalid_off", a_if_valid, 0);
    check("f_irdata_hold", a_if_rdata, 32'h2001_0005);

    // Load then store, LATENCY=1: store must not disturb d_rdata
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    step(); step(); step();
    check("ld_dvalid", a_d_valid, 1);
    check("ld_drdata", a_d_rdata, f(32'h0000_0300));
    d_req = 1'b0;
    step();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
    step();
    check("st_men", a_mem_en, 1);
    check("st_mwe", a_mem_we, 1);
    check("st_maddr", a_mem_addr, 32'h1001_0004);
    check("st_mwdata", a_mem_wdata, 32'hDEAD_BEEF);
    step();
    check("st_men_off", a_mem_en, 0);
    check("st_mwe_off", a_mem_we, 0);
    step();
    check("st_dvalid", a_d_valid, 1);
    check("st_drdata_keep", a_d_rdata, f(32'h0000_0300));
    d_req = 1'b0; d_we = 1'b0;
    step();
    check("st_dvalid_off", a_d_valid, 0);

    // Sustained conflict, LATENCY=3: alternate F,D,... every 6 cycles
    do_reset();
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    if_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
    en_base = b_en_total;
    for (int k = 0; k < 8; k++) begin
      step();                                     // cycle 6k+1
      check("rr_men", b_mem_en, 1);
      check("rr_maddr", b_mem_addr, (k % 2 == 0) ? 32'h0000_1000 : 32'h0000_2000);
      step(); step(); step();                     // cycle 6k+4
      check("rr_novalid", b_if_valid | b_d_valid, 0);
      step();                                     // cycle 6k+5
      if (k % 2 == 0) begin
        check("rr_ivalid", b_if_valid, 1);
        check("rr_dvalid0", b_d_valid, 0);
        check("rr_irdata", b_if_rdata, f(32'h0000_1000));
      end else begin
        check("rr_dvalid", b_d_valid, 1);
        check("rr_ivalid0", b_if_valid, 0);
        check("rr_drdata", b_d_rdata, f(32'h0000_2000));
      end
      step();                                     // cycle 6k+6
      check("rr_idle", b_busy, 0);
    end
    if_req = 1'b0; d_req = 1'b0;
    step(); step();
    check("rr_en_count", b_en_total - en_base, 8);

    // Reset during WAIT, LATENCY=4
    do_reset();
    if_req = 1'b1; if_addr = 32'h0000_0500;       // cycle 0
    step();
    check("rw_men", c_mem_en, 1);
    step(); step();                               // cycle 3 (WAIT)
    check("rw_busy_wait", c_busy, 1);
    rst = 1'b1;
    step();                                       // cycle 4
    check("rw_busy", c_busy, 0);
    check("rw_men0", c_mem_en, 0);
    check("rw_maddr0", c_mem_addr, 0);
    check("rw_ivalid0", c_if_valid, 0);
    check("rw_irdata0", c_if_rdata, 0);
    rst = 1'b0;                                   // new cycle 0
    step();
    check("rw_men_again", c_mem_en, 1);
    check("rw_maddr_again", c_mem_addr, 32'h0000_0500);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rw_no_valid", c_if_valid, 0);
    end
    step();                                       // cycle 6
    check("rw_ivalid", c_if_valid, 1);
    check("rw_irdata", c_if_rdata, f(32'h0000_0500));
    if_req = 1'b0;
    step();                                       // IDLE

    // Fetch address changed during WAIT, LATENCY=4
    if_req = 1'b1; if_addr = 32'h0000_0600;       // cycle 0
    step();
    check("ac_maddr", c_mem_addr, 32'h0000_0600);
    step();
    if_addr = 32'h0000_0700;
    step();
    check("ac_maddr_hold", c_mem_addr, 32'h0000_0600);
    step(); step();
    check("ac_novalid", c_if_valid, 0);
    step();                                       // cycle 6
    check("ac_ivalid", c_if_valid, 1);
    check("ac_irdata", c_if_rdata, f(32'h0000_0600));
    if_req = 1'b0;
    step();
    check("ac_ivalid_off", c_if_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the cpu instruction-fetch requester and its data load/store requester.
- Used when instruction and data memory are merged into one physical RAM.
- Serialises accesses and applies round-robin on conflicts.
- Hides the memory's fixed read latency behind a req/valid handshake; the cpu stalls on `busy`.

Parameters:
- AW, 32, address width
- DW, 32, data width
- LATENCY, 1, cycles from the `mem_en` cycle to valid `mem_rdata`; must be 1..15; 0 is illegal

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; level, held until `if_valid`
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word
- if_valid  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request; level, held until `d_valid`
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data
- d_valid  out  1  one-cycle data completion pulse (loads and stores)
- mem_en  out  1  memory access strobe, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by `mem_en`
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Interface: one clock (`clk`). Reset `rst` is synchronous and active-high.
- All outputs are registered except `busy`, which decodes the state register.
- Reset values:
  - state = IDLE; cnt = 0; last_grant = DATA, so fetch wins the first tie.
  - All outputs 0, including `if_rdata`, `d_rdata`, `mem_addr`, `mem_wdata`.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Samples `if_req` and `d_req` at the clock edge.
  - Neither asserted: stay in IDLE.
  - Exactly one asserted: grant it.
  - Both asserted: grant the requester that is not `last_grant`.
  - On grant: latch `grant`; update `last_grant`; load `mem_addr`, `mem_we` and `mem_wdata` from the granted requester (fetch forces `mem_we` = 0); set `mem_en` = 1; cnt = LATENCY; go to ISSUE.
- ISSUE: `mem_en` is high for this cycle only. Next edge: `mem_en` = 0, `mem_we` = 0; cnt decrements; go to WAIT.
- WAIT:
  - cnt decrements each edge.
  - On the edge where cnt == 0, so `mem_rdata` is valid during this cycle:
    - Fetch grant: `if_rdata` <= `mem_rdata`, `if_valid` <= 1.
    - Data load: `d_rdata` <= `mem_rdata`, `d_valid` <= 1.
    - Data store: `d_valid` <= 1 and `d_rdata` is unchanged.
    - Go to RESP.
- RESP: the valid pulse is high for this cycle. Next edge: valid cleared; go to IDLE.
- Latency: request sampled at the end of cycle 0, `mem_en` in cycle 1, valid in cycle LATENCY+2. Back-to-back accesses occupy LATENCY+3 cycles each.
- Requester rule: a requester must drop or replace `req`, address and data by the edge ending its valid cycle. IDLE re-samples one cycle after RESP, so a held request is serviced again; this is intended for the streaming fetch case.
- Address and data are captured only in IDLE. Changes to requester inputs during ISSUE, WAIT or RESP are ignored.
- `req` dropped mid-access: the access completes and valid still pulses.
- Simultaneous requests, sustained: grants alternate fetch, data, fetch, and so on. Neither requester starves; worst-case wait is one access.
- A new request arriving during RESP of the other requester is sampled in the following IDLE.
- Reset mid-access: state goes to IDLE and all strobes clear on that edge. `mem_rdata` is not captured and no valid is pulsed. A store whose `mem_en` already issued may have completed; this is acceptable.
- `rdata` registers hold their value until the next completing read for the same requester.

Test Plan:
- Reset with both `req` high, LATENCY=1 → first `mem_en` in cycle 1 with fetch address; `if_valid` in cycle 3; `d_valid` never asserts during reset cycles.
- Fetch only, `if_addr`=0x0040_0000, `mem_rdata`=0x2001_0005 in the cycle after `mem_en` → `if_rdata`=0x2001_0005 and a one-cycle `if_valid` at cycle 3; `mem_we`=0.
- Store `d_addr`=0x1001_0004, `d_wdata`=0xDEAD_BEEF → single `mem_en` cycle with `mem_we`=1 and matching address/data; `d_valid` pulses; `d_rdata` keeps its prior value.
- Both `req` held for 8 accesses, LATENCY=3 → grants alternate F,D,F,D…; each access spans 6 cycles; exactly one `mem_en` per access.
- Assert `rst` in WAIT, LATENCY=4 → outputs 0 on the next edge; no valid pulse; after release a pending `if_req` is serviced normally.
- Fetch address changed during WAIT → `mem_addr` keeps the captured value; returned data corresponds to the original address.
